// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding, RAM
// transfer size codes and the grant-selection helper.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_BUSY    = 2'b01,
        ST_RELEASE = 2'b10
    } state_t;

    typedef logic [1:0] size_t;

    localparam size_t SIZE_BYTE = 2'b00;
    localparam size_t SIZE_HALF = 2'b01;
    localparam size_t SIZE_WORD = 2'b11;

    // Returns the index of the master to grant. Only meaningful when at least
    // one cs is high. On a tie, fixed priority picks master 0; round-robin
    // picks the master that was not served last.
    function automatic logic pick_winner(input logic cs0, input logic cs1,
                                         input logic rr_en, input logic last);
        logic win;
        win = 1'b0;
        if (cs0 && cs1)
            win = rr_en ? ~last : 1'b0;
        else if (cs1)
            win = 1'b1;
        return win;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bus between a memory master and a memory slave.
// Handshake: the master raises cs with addr/wdata/we/oe/size and keeps all of
// them stable until it sees ready high for one cycle; ready (with err on an
// aborted access) is a single-cycle pulse, and rdata is valid from the ready
// cycle onward for reads. Holding cs after ready starts a new request.
interface mem_arbiter_if;
    import mem_bus_pkg::*;

    logic [31:0] addr;
    logic [31:0] wdata;
    logic        cs;
    logic        we;
    logic        oe;
    size_t       size;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    modport master (
        output addr, wdata, cs, we, oe, size,
        input  rdata, ready, err
    );

    modport slave (
        input  addr, wdata, cs, we, oe, size,
        output rdata, ready, err
    );

endinterface

// File: rtl/mem_arbiter.sv
// Two-master, single-slave registered arbiter in front of basic_ram.
// Master 0 is the program loader, master 1 the ARMv4 core. Each RAM access
// is latched at grant, held until ram done (ram.ready) or timeout, then a
// one-cycle RELEASE gap deasserts the strobes before the next grant.
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int RR      = 0
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  m0,
    mem_arbiter_if.slave  m1,
    mem_arbiter_if.master ram,
    output state_t        dbg_state
);

    localparam int             CW      = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT - 1);
    localparam logic           RR_EN   = (RR != 0);

    state_t          state;
    logic            owner;
    logic            last_served;
    logic [CW-1:0]   cnt;

    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic            r_cs;
    logic            r_we;
    logic            r_oe;
    size_t           r_size;

    logic [31:0]     m0_rdata_q;
    logic [31:0]     m1_rdata_q;
    logic            m0_ready_q;
    logic            m1_ready_q;
    logic            m0_err_q;
    logic            m1_err_q;

    logic            win;
    logic [31:0]     req_addr;
    logic [31:0]     req_wdata;
    logic            req_we;
    logic            req_oe;
    size_t           req_size;

    // Pick the winner and steer its request fields; feeds registers only.
    always_comb begin
        win       = pick_winner(m0.cs, m1.cs, RR_EN, last_served);
        req_addr  = win ? m1.addr  : m0.addr;
        req_wdata = win ? m1.wdata : m0.wdata;
        req_we    = win ? m1.we    : m0.we;
        req_oe    = win ? m1.oe    : m0.oe;
        req_size  = win ? m1.size  : m0.size;
    end

    // Arbiter FSM: grant in IDLE, hold in BUSY, one strobe-free RELEASE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            owner       <= 1'b0;
            last_served <= 1'b0;
            cnt         <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cs        <= 1'b0;
            r_we        <= 1'b0;
            r_oe        <= 1'b0;
            r_size      <= '0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            m0_ready_q  <= 1'b0;
            m1_ready_q  <= 1'b0;
            m0_err_q    <= 1'b0;
            m1_err_q    <= 1'b0;
        end else begin
            m0_ready_q <= 1'b0;
            m1_ready_q <= 1'b0;
            m0_err_q   <= 1'b0;
            m1_err_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (m0.cs || m1.cs) begin
                        owner       <= win;
                        last_served <= win;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_we        <= req_we;
                        r_oe        <= req_oe;
                        r_size      <= req_size;
                        r_cs        <= 1'b1;
                        cnt         <= '0;
                        state       <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (ram.ready) begin
                        // Only reads update the owner's read data.
                        if (r_oe) begin
                            if (owner) m1_rdata_q <= ram.rdata;
                            else       m0_rdata_q <= ram.rdata;
                        end
                        if (owner) m1_ready_q <= 1'b1;
                        else       m0_ready_q <= 1'b1;
                        r_cs  <= 1'b0;
                        r_we  <= 1'b0;
                        r_oe  <= 1'b0;
                        state <= ST_RELEASE;
                    end else if (cnt == CNT_MAX) begin
                        if (owner) begin
                            m1_ready_q <= 1'b1;
                            m1_err_q   <= 1'b1;
                        end else begin
                            m0_ready_q <= 1'b1;
                            m0_err_q   <= 1'b1;
                        end
                        r_cs  <= 1'b0;
                        r_we  <= 1'b0;
                        r_oe  <= 1'b0;
                        state <= ST_RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ram.addr  = r_addr;
    assign ram.wdata = r_wdata;
    assign ram.cs    = r_cs;
    assign ram.we    = r_we;
    assign ram.oe    = r_oe;
    assign ram.size  = r_size;

    assign m0.rdata  = m0_rdata_q;
    assign m0.ready  = m0_ready_q;
    assign m0.err    = m0_err_q;
    assign m1.rdata  = m1_rdata_q;
    assign m1.ready  = m1_ready_q;
    assign m1.err    = m1_err_q;

    assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Two instances share one stimulus stream:
// dut_a uses fixed priority, dut_b round-robin; both use TIMEOUT=8.
module tb_mem_arbiter;
    import mem_bus_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_arbiter_if a_m0 ();
    mem_arbiter_if a_m1 ();
    mem_arbiter_if a_ram ();
    mem_arbiter_if b_m0 ();
    mem_arbiter_if b_m1 ();
    mem_arbiter_if b_ram ();

    state_t a_state;
    state_t b_state;

    mem_arbiter #(.TIMEOUT(8), .RR(0)) dut_a (
        .clk(clk), .rst(rst), .m0(a_m0), .m1(a_m1), .ram(a_ram), .dbg_state(a_state)
    );

    mem_arbiter #(.TIMEOUT(8), .RR(1)) dut_b (
        .clk(clk), .rst(rst), .m0(b_m0), .m1(b_m1), .ram(b_ram), .dbg_state(b_state)
    );

    // Mirror the driven inputs of dut_a onto dut_b.
    assign b_m0.addr  = a_m0.addr;
    assign b_m0.wdata = a_m0.wdata;
    assign b_m0.cs    = a_m0.cs;
    assign b_m0.we    = a_m0.we;
    assign b_m0.oe    = a_m0.oe;
    assign b_m0.size  = a_m0.size;
    assign b_m1.addr  = a_m1.addr;
    assign b_m1.wdata = a_m1.wdata;
    assign b_m1.cs    = a_m1.cs;
    assign b_m1.we    = a_m1.we;
    assign b_m1.oe    = a_m1.oe;
    assign b_m1.size  = a_m1.size;
    assign b_ram.rdata = a_ram.rdata;
    assign b_ram.ready = a_ram.ready;
    assign b_ram.err   = a_ram.err;

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        a_m0.cs = 1'b0; a_m0.we = 1'b0; a_m0.oe = 1'b0;
        a_m1.cs = 1'b0; a_m1.we = 1'b0; a_m1.oe = 1'b0;
        a_ram.ready = 1'b0;
    endtask

    logic [31:0] rr_addr [4];
    logic        rr_win  [4];

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        a_m0.addr = '0; a_m0.wdata = '0; a_m0.size = SIZE_WORD;
        a_m1.addr = '0; a_m1.wdata = '0; a_m1.size = SIZE_WORD;
        a_ram.rdata = '0; a_ram.err = 1'b0;
        idle_inputs();

        // ---- reset state
        tick();
        tick();
        chk("rst_ram_cs",   32'(a_ram.cs), 32'd0);
        chk("rst_ram_addr", a_ram.addr, 32'd0);
        chk("rst_m0_ready", 32'(a_m0.ready), 32'd0);
        chk("rst_m1_rdata", a_m1.rdata, 32'd0);
        chk("rst_state",    32'(a_state), 32'(ST_IDLE));
        rst = 1'b1;
        tick();

        // ---- single read by master 1, RAM answers after 3 cycles
        a_m1.cs = 1'b1; a_m1.oe = 1'b1; a_m1.addr = 32'h10; a_m1.size = SIZE_WORD;
        tick();
        chk("rd_ram_cs",   32'(a_ram.cs), 32'd1);
        chk("rd_ram_addr", a_ram.addr, 32'h10);
        chk("rd_ram_oe",   32'(a_ram.oe), 32'd1);
        chk("rd_ram_size", 32'(a_ram.size), 32'(SIZE_WORD));
        chk("rd_state",    32'(a_state), 32'(ST_BUSY));
        tick();
        tick();
        chk("rd_wait_ready", 32'(a_m1.ready), 32'd0);
        a_ram.ready = 1'b1; a_ram.rdata = 32'hE3A00001;
        tick();
        chk("rd_m1_ready", 32'(a_m1.ready), 32'd1);
        chk("rd_m1_rdata", a_m1.rdata, 32'hE3A00001);
        chk("rd_m0_ready", 32'(a_m0.ready), 32'd0);
        chk("rd_cs_low",   32'(a_ram.cs), 32'd0);
        chk("rd_release",  32'(a_state), 32'(ST_RELEASE));
        a_ram.ready = 1'b0; a_m1.cs = 1'b0; a_m1.oe = 1'b0;
        tick();
        chk("rd_ready_pulse", 32'(a_m1.ready), 32'd0);
        chk("rd_idle",        32'(a_state), 32'(ST_IDLE));
        chk("rd_b_rdata",     b_m1.rdata, 32'hE3A00001);

        // ---- simultaneous requests, fixed priority: m0 write first
        a_m0.cs = 1'b1; a_m0.we = 1'b1; a_m0.addr = 32'h0; a_m0.wdata = 32'hDEADBEEF;
        a_m0.size = SIZE_BYTE;
        a_m1.cs = 1'b1; a_m1.oe = 1'b1; a_m1.addr = 32'h20;
        tick();
        chk("fp_addr0",  a_ram.addr, 32'h0);
        chk("fp_wdata",  a_ram.wdata, 32'hDEADBEEF);
        chk("fp_we",     32'(a_ram.we), 32'd1);
        chk("fp_size",   32'(a_ram.size), 32'(SIZE_BYTE));
        tick();
        a_ram.ready = 1'b1; a_ram.rdata = 32'h55555555;
        tick();
        chk("fp_m0_ready", 32'(a_m0.ready), 32'd1);
        chk("fp_m1_ready", 32'(a_m1.ready), 32'd0);
        chk("fp_m0_rdata_wr", a_m0.rdata, 32'd0);
        a_ram.ready = 1'b0; a_m0.cs = 1'b0; a_m0.we = 1'b0;
        tick();
        chk("fp_gap_cs", 32'(a_ram.cs), 32'd0);
        tick();
        chk("fp_m1_cs",   32'(a_ram.cs), 32'd1);
        chk("fp_m1_addr", a_ram.addr, 32'h20);
        a_ram.ready = 1'b1; a_ram.rdata = 32'h12345678;
        tick();
        chk("fp_m1_done",  32'(a_m1.ready), 32'd1);
        chk("fp_m1_rdata", a_m1.rdata, 32'h12345678);
        idle_inputs();
        tick();
        tick();

        // ---- round-robin alternation after a fresh reset
        rst = 1'b0;
        tick();
        rst = 1'b1;
        rr_addr = '{32'h200, 32'h100, 32'h200, 32'h100};
        rr_win  = '{1'b1, 1'b0, 1'b1, 1'b0};
        a_m0.cs = 1'b1; a_m0.we = 1'b1; a_m0.addr = 32'h100; a_m0.wdata = 32'hA0A0A0A0;
        a_m1.cs = 1'b1; a_m1.oe = 1'b1; a_m1.addr = 32'h200;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rr_addr_%0d", i), b_ram.addr, rr_addr[i]);
            chk($sformatf("fp_hold_%0d", i), a_ram.addr, 32'h100);
            a_ram.ready = 1'b1; a_ram.rdata = 32'h0000_0100 + 32'(i);
            tick();
            chk($sformatf("rr_m1rdy_%0d", i), 32'(b_m1.ready), 32'(rr_win[i]));
            chk($sformatf("rr_m0rdy_%0d", i), 32'(b_m0.ready), 32'(!rr_win[i]));
            a_ram.ready = 1'b0;
            tick();
            chk($sformatf("rr_gap_%0d", i), 32'(b_ram.cs), 32'd0);
        end
        idle_inputs();
        tick();
        tick();

        // ---- master 0 changes address mid-BUSY
        a_m0.cs = 1'b1; a_m0.oe = 1'b1; a_m0.addr = 32'h4; a_m0.size = SIZE_HALF;
        tick();
        chk("hold_addr_a", a_ram.addr, 32'h4);
        a_m0.addr = 32'h8; a_m0.size = SIZE_WORD;
        tick();
        chk("hold_addr_b", a_ram.addr, 32'h4);
        tick();
        chk("hold_addr_c", a_ram.addr, 32'h4);
        chk("hold_size",   32'(a_ram.size), 32'(SIZE_HALF));
        a_ram.ready = 1'b1; a_ram.rdata = 32'hAAAA5555;
        tick();
        chk("hold_m0_rdata", a_m0.rdata, 32'hAAAA5555);
        chk("hold_addr_d",   a_ram.addr, 32'h4);
        idle_inputs();
        tick();
        tick();

        // ---- timeout: ram done never arrives
        a_m1.cs = 1'b1; a_m1.oe = 1'b1; a_m1.addr = 32'h30;
        a_ram.rdata = 32'hBADBAD00;
        tick();
        chk("to_cs", 32'(a_ram.cs), 32'd1);
        for (int i = 0; i < 7; i++) tick();
        chk("to_not_yet", 32'(a_m1.ready), 32'd0);
        chk("to_busy",    32'(a_state), 32'(ST_BUSY));
        tick();
        chk("to_ready", 32'(a_m1.ready), 32'd1);
        chk("to_err",   32'(a_m1.err), 32'd1);
        chk("to_rdata", a_m1.rdata, 32'd0);
        chk("to_cs_lo", 32'(a_ram.cs), 32'd0);
        idle_inputs();
        tick();
        chk("to_err_pulse", 32'(a_m1.err), 32'd0);
        tick();

        // ---- asynchronous reset during BUSY
        a_m0.cs = 1'b1; a_m0.oe = 1'b1; a_m0.addr = 32'h40;
        tick();
        chk("ar_cs_hi", 32'(a_ram.cs), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_cs_async", 32'(a_ram.cs), 32'd0);
        chk("ar_state",    32'(a_state), 32'(ST_IDLE));
        a_m0.cs = 1'b0; a_m0.oe = 1'b0;
        tick();
        chk("ar_no_ready", 32'(a_m0.ready), 32'd0);
        rst = 1'b1;
        tick();
        a_m0.cs = 1'b1; a_m0.oe = 1'b1; a_m0.addr = 32'h44;
        tick();
        chk("ar_new_cs",   32'(a_ram.cs), 32'd1);
        chk("ar_new_addr", a_ram.addr, 32'h44);
        a_ram.ready = 1'b1; a_ram.rdata = 32'h13579BDF;
        tick();
        chk("ar_new_ready", 32'(a_m0.ready), 32'd1);
        chk("ar_new_rdata", a_m0.rdata, 32'h13579BDF);
        idle_inputs();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
